// File: rtl/platform_ledr_pwm.sv
// LEDR output stage: global PWM brightness and per-LED blinking, configured over Avalon-MM, registered led drive.
// Latency 1 clk from pattern/config to led; no backpressure. Optional macro LEDR_PWM_GAMMA_EN squares duty for the compare.
module platform_ledr_pwm #(
    parameter int PRESCALE = 50000,
    parameter int NLED     = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NLED-1:0] pattern,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [NLED-1:0] led
);

    logic [7:0]      duty;
    logic [NLED-1:0] blink_mask;
    logic [15:0]     blink_period;
    logic            phase;
    logic [7:0]      pwm_cnt;
    logic [15:0]     pre_cnt;
    logic [15:0]     blink_cnt;

    logic            wr;
    logic            tick;
    logic [7:0]      duty_eff;
    logic            pwm_on;

    assign wr   = chipselect && !write_n;
    assign tick = (pre_cnt == 16'(PRESCALE - 1));

`ifdef LEDR_PWM_GAMMA_EN
    logic [15:0] duty_sq;
    logic        unused_sq;
    assign duty_sq   = {8'b0, duty} * {8'b0, duty};
    assign duty_eff  = duty_sq[15:8];
    assign unused_sq = &{1'b0, duty_sq[7:0]};
`else
    assign duty_eff = duty;
`endif

    // Full scale is forced on so duty 255 never drops the cycle where pwm_cnt == 255.
    assign pwm_on = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty_eff);

    logic unused_wd;
    assign unused_wd = &{1'b0, writedata[31:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            duty         <= 8'hFF;
            blink_mask   <= '0;
            blink_period <= 16'h0000;
            phase        <= 1'b1;
            pwm_cnt      <= 8'd0;
            pre_cnt      <= 16'd0;
            blink_cnt    <= 16'd0;
            led          <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led     <= pattern & {NLED{pwm_on}} & (~blink_mask | {NLED{phase}});

            if (wr && address == 2'd0) duty <= writedata[7:0];
            if (wr && address == 2'd1) blink_mask <= writedata[NLED-1:0];

            // A period write restarts the blink timeline and wins over a coincident tick.
            if (wr && address == 2'd2) begin
                blink_period <= writedata[15:0];
                blink_cnt    <= 16'd0;
                pre_cnt      <= 16'd0;
                phase        <= 1'b1;
            end else begin
                pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
                if (blink_period == 16'd0) begin
                    phase     <= 1'b1;
                    blink_cnt <= 16'd0;
                end else if (tick) begin
                    if (blink_cnt == blink_period - 16'd1) begin
                        blink_cnt <= 16'd0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {24'd0, duty};
            2'd1:    readdata = {{(32-NLED){1'b0}}, blink_mask};
            2'd2:    readdata = {16'd0, blink_period};
            default: readdata = {16'd0, pwm_cnt, 7'd0, phase};
        endcase
    end

endmodule

// File: tb/tb_platform_ledr_pwm.sv
// Scoreboarded bench for platform_ledr_pwm with PRESCALE = 4.
module tb_platform_ledr_pwm;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pattern;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  led;

    always #5 clk = ~clk;

    platform_ledr_pwm #(.PRESCALE(4), .NLED(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .pattern    (pattern),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led        (led)
    );

    int total = 0;
    int bad   = 0;
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        if (sb_exp.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Expected high cycles of a lit LED over 256 clk for a given raw duty.
    function automatic int exp_on(input int d);
        if (d == 255) return 256;
`ifdef LEDR_PWM_GAMMA_EN
        return (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    task automatic count_high0(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (led[0]) c++;
        end
    endtask

    // Clocks until led[1] changes; -1 if it never does within the bound.
    task automatic wait_led1(output int n, inout int zeros0);
        logic prev;
        prev = led[1];
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!led[0]) zeros0++;
            if (led[1] != prev) begin
                n = i;
                break;
            end
        end
    endtask

    logic [31:0] d;
    int c, n, z0;

    initial begin
        reset = 1'b1; pattern = 10'h3FF; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

        // Reset held 3 clk
        repeat (3) begin
            @(negedge clk);
            sb_push("rst_led", 32'd0);
            sb_check({22'd0, led});
        end
        rd(2'd0, d); sb_push("rst_duty", 32'hFF); sb_check(d);
        rd(2'd1, d); sb_push("rst_mask", 32'h0);  sb_check(d);
        rd(2'd2, d); sb_push("rst_period", 32'h0); sb_check(d);
        rd(2'd3, d); sb_push("rst_status", 32'h1); sb_check(d);
        reset = 1'b0;
        sb_push("post_rst_steady", 32'd0);
        c = 0;
        repeat (20) begin
            @(negedge clk);
            if (led !== 10'h3FF) c++;
        end
        sb_check(c);

        // PWM duty 64 and 128
        pattern = 10'h001;
        wr(2'd0, 32'd64);
        repeat (2) @(negedge clk);
        sb_push("pwm_64", exp_on(64));
        count_high0(256, c); sb_check(c);
        wr(2'd0, 32'd128);
        rd(2'd0, d); sb_push("rd_duty_raw", 32'd128); sb_check(d);
        repeat (2) @(negedge clk);
        sb_push("pwm_128", exp_on(128));
        count_high0(256, c); sb_check(c);

        // Duty extremes
        pattern = 10'h3FF;
        wr(2'd0, 32'd0);
        repeat (2) @(negedge clk);
        sb_push("duty0_dark", 32'd0);
        c = 0;
        repeat (512) begin @(negedge clk); if (led !== 10'h000) c++; end
        sb_check(c);
        wr(2'd0, 32'd255);
        repeat (2) @(negedge clk);
        sb_push("duty255_full", 32'd0);
        c = 0;
        repeat (512) begin @(negedge clk); if (led !== pattern) c++; end
        sb_check(c);

        // Blink: PRESCALE 4, period 3 -> 12 clk half-period
        pattern = 10'h003;
        wr(2'd1, 32'h002);
        wr(2'd2, 32'd3);
        z0 = 0;
        sb_push("blink_first", 32'd13);
        wait_led1(n, z0); sb_check(n);
        for (int k = 0; k < 3; k++) begin
            sb_push("blink_half", 32'd12);
            wait_led1(n, z0); sb_check(n);
        end
        sb_push("led0_steady", 32'd0); sb_check(z0);

        // Period rewrite while phase = 0
        n = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rd(2'd3, d);
            if (d[0] == 1'b0) begin n = i; break; end
        end
        sb_push("phase0_seen", 32'd1); sb_check(n >= 0);
        repeat (4) @(negedge clk);
        wr(2'd2, 32'd3);
        rd(2'd3, d); sb_push("phase_restart", 32'd1); sb_check({31'd0, d[0]});
        n = -1;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            rd(2'd3, d);
            if (d[0] == 1'b0) begin n = j; break; end
        end
        sb_push("toggle_after_rewrite", 32'd12); sb_check(n);
        @(negedge clk);
        sb_push("led1_follows", 32'd0); sb_check({31'd0, led[1]});

        // Writes to addr 3 are ignored
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd0, d); sb_push("ro_duty", 32'hFF);  sb_check(d);
        rd(2'd1, d); sb_push("ro_mask", 32'h2);   sb_check(d);
        rd(2'd2, d); sb_push("ro_period", 32'h3); sb_check(d);

        // Reset mid-operation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_push("midrst_led", 32'd0);   sb_check({22'd0, led});
        rd(2'd0, d); sb_push("midrst_duty", 32'hFF); sb_check(d);
        rd(2'd1, d); sb_push("midrst_mask", 32'h0);  sb_check(d);
        rd(2'd2, d); sb_push("midrst_period", 32'h0); sb_check(d);
        rd(2'd3, d); sb_push("midrst_status", 32'h1); sb_check(d);

        sb_push("sb_drained", 32'd0); sb_check(sb_exp.size() - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
